umni_controller: RTL and testbench
==================================

// Module: umni_controller
// PURPOSE
//  Humidifier controller. Averages four humidity sensors and smooths the average over the last 4 samples.
//  Compares the smoothed humidity to a user setpoint and drives the humidifier (on/off, power) and an internal LED.
//  Shows the smoothed humidity on three 7-segment displays. Top-level block between the sensor front-end and the actuators/panel.
// PARAMETERS
//  SAMPLE_DIV  1    clocks per sample tick (1 = sample every clock); history and average update only on ticks
//  MAX_HUM     100  saturation limit (%) applied to sensors, setpoint and power
//  HYST        3    hysteresis band (%), used only with UMNI_HYST_EN
// PORTS
//  clock_geral             in   1  system clock, all state on rising edge
//  reset_geral             in   1  synchronous, active-high reset
//  sensor1..sensor4        in   7  raw humidity readings (%)
//  umidadeRef              in   7  desired humidity (%)
//  ajuste_de_modo          in   7  requested vaporizer power (%)
//  botao_LED               in   1  level button; rising edge toggles LED enable
//  botao_on_off            in   1  level button; rising edge toggles humidifier enable
//  umidade_atual_media     out  7  registered mean of 4 sensors, last tick
//  umidade_atual_temporal  out  7  registered mean of the last 4 sensor means
//  LED_int_ligada          out  1  LED enable state (toggle register)
//  umidificador_ligado     out  1  humidifier enable state (toggle register)
//  LED_int                 out  1  internal LED drive
//  umidificador_on_off     out  1  humidifier drive
//  pot_umidade             out  7  applied power (%), 0 when humidifier not driven
//  LED_func                out  1  "system operational": history filled
//  display1_final          out  7  units digit, segments abcdefg (bit6=a)
//  display2_final          out  7  tens digit
//  display3_final          out  7  hundreds digit
// BEHAVIOUR
//  - Reset: all registers 0. History 0, means 0, enables 0, LED_func 0, drives 0, pot 0, displays ZERO/ZERO/ZERO.
//  - Each sensor saturated to MAX_HUM. mean = (s1+s2+s3+s4)>>2, 9-bit sum, truncating.
//  - Tick edge: umidade_atual_media <= mean; 4-entry history shifts in mean (oldest dropped); fill counter++ (saturates at 4).
//  - Edge after tick: umidade_atual_temporal <= (h0+h1+h2+h3)>>2. Sensor->temporal latency = 2 clocks (SAMPLE_DIV=1).
//  - LED_func = 1 once fill counter reaches 4; stays 1 until reset.
//  - Buttons: registered previous level; a 0->1 edge toggles the matching enable on the next clock.
//    Button edges are evaluated every clock, independent of tick. Simultaneous edges on both buttons toggle both.
//  - Demand (no macro): need = temporal < sat(umidadeRef). Equality -> no demand.
//  - LED_int = LED_int_ligada & need. umidificador_on_off = umidificador_ligado & need. All combinational from registers.
//  - pot_umidade = umidificador_on_off ? sat(ajuste_de_modo) : 0.
//  - Displays: temporal (0..100) split into hundreds/tens/units; each digit decoded to a 7-segment code:
//    0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=0011111 7=1110000 8=1111111 9=1110011.
//    Codes above 9 are unreachable; decode them as 0000000.
//  - Reset mid-operation clears history, and LED_func drops to 0 until 4 new ticks.
// CONFIGURATION
//  UMNI_HYST_EN defined: need is a registered flag.
//    - Set when temporal < ref.
//    - Cleared when temporal >= ref+HYST, saturating at MAX_HUM.
//    - Otherwise holds its value; reset value 0.
//  Undefined: need is the plain combinational compare above.
// STRUCTURE
//  umni_pkg: segment constants ZERO..NOVE, MAX_HUM, saturate function.
//  Sub-module umni_seg7_dec (4-bit digit -> 7-bit code), instantiated 3x. Everything else in umni_controller.
// TESTING
//  1 Reset high 2 clk -> all outputs 0, displays 1111110 x3, LED_func=0.
//  2 Sensors 40,60,50,50 held 6 clk -> media=50, temporal=50, LED_func=1, displays ZERO/CINCO/ZERO (hundreds/tens/units).
//  3 Sensors 127x4 -> saturated to 100, temporal=100, displays UM/ZERO/ZERO.
//  4 temporal=50, ref=70, one botao_on_off pulse, ajuste_de_modo=90 -> umidificador_ligado=1, on_off=1, pot=90;
//    second pulse -> 0, pot=0.
//  5 temporal=80, ref=70, both enables 1 -> LED_int=0, on_off=0, pot=0; with temporal=70 -> still 0.
//  6 UMNI_HYST_EN, ref=70: temporal 69 -> need=1; 72 -> holds 1; 73 -> need=0.

Source files
------------

// File: rtl/umni_pkg.sv
// umni_pkg: shared constants and helpers for the humidifier controller.
// Rev 1.0 - initial release.
`default_nettype none

package umni_pkg;

  localparam logic [6:0] ZERO    = 7'b1111110;
  localparam logic [6:0] UM      = 7'b0110000;
  localparam logic [6:0] DOIS    = 7'b1101101;
  localparam logic [6:0] TRES    = 7'b1111001;
  localparam logic [6:0] QUATRO  = 7'b0110011;
  localparam logic [6:0] CINCO   = 7'b1011011;
  localparam logic [6:0] SEIS    = 7'b0011111;
  localparam logic [6:0] SETE    = 7'b1110000;
  localparam logic [6:0] OITO    = 7'b1111111;
  localparam logic [6:0] NOVE    = 7'b1110011;
  localparam logic [6:0] APAGADO = 7'b0000000;

  localparam int MAX_HUM = 100;

  function automatic logic [6:0] saturate(input logic [6:0] value, input logic [6:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

`default_nettype wire

// File: rtl/umni_seg7_dec.sv
// umni_seg7_dec: BCD digit to 7-segment code (abcdefg, bit6 = a).
// Rev 1.0 - initial release.
`default_nettype none

module umni_seg7_dec (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);
  import umni_pkg::*;

  always_comb begin
    seg_o = APAGADO;
    case (digit_i)
      4'd0:    seg_o = ZERO;
      4'd1:    seg_o = UM;
      4'd2:    seg_o = DOIS;
      4'd3:    seg_o = TRES;
      4'd4:    seg_o = QUATRO;
      4'd5:    seg_o = CINCO;
      4'd6:    seg_o = SEIS;
      4'd7:    seg_o = SETE;
      4'd8:    seg_o = OITO;
      4'd9:    seg_o = NOVE;
      default: seg_o = APAGADO;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/umni_controller.sv
// umni_controller: humidifier controller (sensor averaging, smoothing, demand, drives, displays).
// Optional UMNI_HYST_EN: registered demand flag with hysteresis. Rev 1.0 - initial release.
`default_nettype none

module umni_controller #(
  parameter int SAMPLE_DIV = 1,
  parameter int MAX_HUM    = umni_pkg::MAX_HUM
`ifdef UMNI_HYST_EN
  ,
  parameter int HYST       = 3
`endif
) (
  input  logic       clock_geral,
  input  logic       reset_geral,
  input  logic [6:0] sensor1,
  input  logic [6:0] sensor2,
  input  logic [6:0] sensor3,
  input  logic [6:0] sensor4,
  input  logic [6:0] umidadeRef,
  input  logic [6:0] ajuste_de_modo,
  input  logic       botao_LED,
  input  logic       botao_on_off,
  output logic [6:0] umidade_atual_media,
  output logic [6:0] umidade_atual_temporal,
  output logic       LED_int_ligada,
  output logic       umidificador_ligado,
  output logic       LED_int,
  output logic       umidificador_on_off,
  output logic [6:0] pot_umidade,
  output logic       LED_func,
  output logic [6:0] display1_final,
  output logic [6:0] display2_final,
  output logic [6:0] display3_final
);
  import umni_pkg::*;

  localparam logic [6:0] LIM = 7'(MAX_HUM);

  logic       tick;
  logic [6:0] s1, s2, s3, s4, ref_sat;
  logic [8:0] sensor_sum, hist_sum;
  logic [6:0] mean;
  logic       need;

  logic [6:0] media_q, media_d;
  logic [6:0] temporal_q, temporal_d;
  logic [6:0] hist_q [4];
  logic [6:0] hist_d [4];
  logic [2:0] fill_q, fill_d;
  logic       led_en_q, led_en_d, hum_en_q, hum_en_d;
  logic       led_btn_q, hum_btn_q;

  generate
    if (SAMPLE_DIV > 1) begin : g_div
      localparam int DIV_W = $clog2(SAMPLE_DIV);
      logic [DIV_W-1:0] div_q;
      always_ff @(posedge clock_geral) begin
        if (reset_geral || div_q == DIV_W'(SAMPLE_DIV - 1)) div_q <= '0;
        else                                                div_q <= div_q + 1'b1;
      end
      assign tick = (div_q == DIV_W'(SAMPLE_DIV - 1));
    end else begin : g_nodiv
      assign tick = 1'b1;
    end
  endgenerate

  assign s1         = saturate(sensor1, LIM);
  assign s2         = saturate(sensor2, LIM);
  assign s3         = saturate(sensor3, LIM);
  assign s4         = saturate(sensor4, LIM);
  assign ref_sat    = saturate(umidadeRef, LIM);
  assign sensor_sum = {2'b00, s1} + {2'b00, s2} + {2'b00, s3} + {2'b00, s4};
  assign mean       = sensor_sum[8:2];
  assign hist_sum   = {2'b00, hist_q[0]} + {2'b00, hist_q[1]} + {2'b00, hist_q[2]} + {2'b00, hist_q[3]};

  always_comb begin
    media_d = media_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    if (tick) begin
      media_d   = mean;
      hist_d[0] = mean;
      hist_d[1] = hist_q[0];
      hist_d[2] = hist_q[1];
      hist_d[3] = hist_q[2];
      if (fill_q != 3'd4) fill_d = fill_q + 3'd1;
    end
    // History only moves on ticks, so this lands one clock after each tick.
    temporal_d = hist_sum[8:2];
    led_en_d   = led_en_q ^ (botao_LED & ~led_btn_q);
    hum_en_d   = hum_en_q ^ (botao_on_off & ~hum_btn_q);
  end

  always_ff @(posedge clock_geral) begin
    if (reset_geral) begin
      media_q    <= '0;
      temporal_q <= '0;
      hist_q     <= '{default: 7'd0};
      fill_q     <= '0;
      led_en_q   <= 1'b0;
      hum_en_q   <= 1'b0;
      led_btn_q  <= 1'b0;
      hum_btn_q  <= 1'b0;
    end else begin
      media_q    <= media_d;
      temporal_q <= temporal_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      led_en_q   <= led_en_d;
      hum_en_q   <= hum_en_d;
      led_btn_q  <= botao_LED;
      hum_btn_q  <= botao_on_off;
    end
  end

`ifdef UMNI_HYST_EN
  logic       need_q, need_d;
  logic [7:0] ref_hi;

  always_comb begin
    ref_hi = {1'b0, ref_sat} + 8'(HYST);
    if (ref_hi > {1'b0, LIM}) ref_hi = {1'b0, LIM};
    need_d = need_q;
    if (temporal_q < ref_sat)              need_d = 1'b1;
    else if ({1'b0, temporal_q} >= ref_hi) need_d = 1'b0;
  end

  always_ff @(posedge clock_geral) begin
    if (reset_geral) need_q <= 1'b0;
    else             need_q <= need_d;
  end

  assign need = need_q;
`else
  assign need = (temporal_q < ref_sat);
`endif

  assign umidade_atual_media    = media_q;
  assign umidade_atual_temporal = temporal_q;
  assign LED_int_ligada         = led_en_q;
  assign umidificador_ligado    = hum_en_q;
  assign LED_int                = led_en_q & need;
  assign umidificador_on_off    = hum_en_q & need;
  assign pot_umidade            = umidificador_on_off ? saturate(ajuste_de_modo, LIM) : 7'd0;
  assign LED_func               = (fill_q == 3'd4);

  logic       hundreds;
  logic [6:0] rem, tens_full, units_full;

  always_comb begin
    hundreds   = (temporal_q >= 7'd100);
    rem        = hundreds ? (temporal_q - 7'd100) : temporal_q;
    tens_full  = rem / 7'd10;
    units_full = rem % 7'd10;
  end

  umni_seg7_dec u_dec_units (
    .digit_i (units_full[3:0]),
    .seg_o   (display1_final)
  );

  umni_seg7_dec u_dec_tens (
    .digit_i (tens_full[3:0]),
    .seg_o   (display2_final)
  );

  umni_seg7_dec u_dec_hundreds (
    .digit_i ({3'b000, hundreds}),
    .seg_o   (display3_final)
  );

endmodule

`default_nettype wire

// File: tb/tb_umni_controller.sv
// tb_umni_controller: directed self-checking bench for umni_controller.
// Rev 1.0 - initial release.
`default_nettype none

module tb_umni_controller;

  localparam logic [6:0] SEG_ZERO   = 7'b1111110;
  localparam logic [6:0] SEG_UM     = 7'b0110000;
  localparam logic [6:0] SEG_QUATRO = 7'b0110011;
  localparam logic [6:0] SEG_CINCO  = 7'b1011011;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] s1, s2, s3, s4, ref_h, ajuste;
  logic       b_led, b_onoff;
  logic [6:0] media, temporal, pot, d1, d2, d3;
  logic       led_lig, hum_lig, led_int, on_off, led_func;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  umni_controller dut (
    .clock_geral            (clk),
    .reset_geral            (rst),
    .sensor1                (s1),
    .sensor2                (s2),
    .sensor3                (s3),
    .sensor4                (s4),
    .umidadeRef             (ref_h),
    .ajuste_de_modo         (ajuste),
    .botao_LED              (b_led),
    .botao_on_off           (b_onoff),
    .umidade_atual_media    (media),
    .umidade_atual_temporal (temporal),
    .LED_int_ligada         (led_lig),
    .umidificador_ligado    (hum_lig),
    .LED_int                (led_int),
    .umidificador_on_off    (on_off),
    .pot_umidade            (pot),
    .LED_func               (led_func),
    .display1_final         (d1),
    .display2_final         (d2),
    .display3_final         (d3)
  );

  task automatic chk(input string tag, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sensors(input int a, input int b, input int c, input int d);
    s1 = 7'(a); s2 = 7'(b); s3 = 7'(c); s4 = 7'(d);
  endtask

  initial begin
    rst = 1'b1; set_sensors(0, 0, 0, 0);
    ref_h = 7'd0; ajuste = 7'd0; b_led = 1'b0; b_onoff = 1'b0;
    cyc(2);
    chk("rst_media", media, 0);
    chk("rst_temporal", temporal, 0);
    chk("rst_led_lig", led_lig, 0);
    chk("rst_hum_lig", hum_lig, 0);
    chk("rst_led_int", led_int, 0);
    chk("rst_on_off", on_off, 0);
    chk("rst_pot", pot, 0);
    chk("rst_led_func", led_func, 0);
    chk("rst_d1", d1, SEG_ZERO);
    chk("rst_d2", d2, SEG_ZERO);
    chk("rst_d3", d3, SEG_ZERO);

    // 40,60,50,50 -> mean 50; temporal ramps 0,12,25,37,50
    rst = 1'b0; set_sensors(40, 60, 50, 50);
    cyc(1);
    chk("lat_media", media, 50);
    chk("lat_temporal1", temporal, 0);
    cyc(1);
    chk("lat_temporal2", temporal, 12);
    cyc(1);
    chk("lat_temporal3", temporal, 25);
    chk("fill3_led_func", led_func, 0);
    cyc(1);
    chk("fill4_led_func", led_func, 1);
    chk("lat_temporal4", temporal, 37);
    cyc(2);
    chk("t2_media", media, 50);
    chk("t2_temporal", temporal, 50);
    chk("t2_d3", d3, SEG_ZERO);
    chk("t2_d2", d2, SEG_CINCO);
    chk("t2_d1", d1, SEG_ZERO);

    // 43+44+45+46 = 178 -> 44 (truncated)
    set_sensors(43, 44, 45, 46);
    cyc(6);
    chk("trunc_media", media, 44);
    chk("trunc_temporal", temporal, 44);
    chk("trunc_d2", d2, SEG_QUATRO);
    chk("trunc_d1", d1, SEG_QUATRO);

    set_sensors(127, 127, 127, 127);
    cyc(6);
    chk("sat_media", media, 100);
    chk("sat_temporal", temporal, 100);
    chk("sat_d3", d3, SEG_UM);
    chk("sat_d2", d2, SEG_ZERO);
    chk("sat_d1", d1, SEG_ZERO);

    set_sensors(50, 50, 50, 50); ref_h = 7'd70; ajuste = 7'd90;
    cyc(6);
    chk("pre_on_off", on_off, 0);
    chk("pre_pot", pot, 0);
    b_onoff = 1'b1;
    cyc(1);
    chk("press1_hum_lig", hum_lig, 1);
    chk("press1_on_off", on_off, 1);
    chk("press1_pot", pot, 90);
    chk("press1_led_int", led_int, 0);
    ajuste = 7'd127;
    cyc(1);
    chk("held_hum_lig", hum_lig, 1);
    chk("pot_sat", pot, 100);
    b_onoff = 1'b0; ajuste = 7'd90;
    cyc(1);
    b_onoff = 1'b1;
    cyc(1);
    chk("press2_hum_lig", hum_lig, 0);
    chk("press2_on_off", on_off, 0);
    chk("press2_pot", pot, 0);
    b_onoff = 1'b0;
    cyc(1);

    b_led = 1'b1; b_onoff = 1'b1;
    cyc(1);
    chk("both_led_lig", led_lig, 1);
    chk("both_hum_lig", hum_lig, 1);
    chk("both_led_int", led_int, 1);
    b_led = 1'b0; b_onoff = 1'b0;

    set_sensors(80, 80, 80, 80);
    cyc(6);
    chk("t80_temporal", temporal, 80);
    chk("t80_led_int", led_int, 0);
    chk("t80_on_off", on_off, 0);
    chk("t80_pot", pot, 0);

    set_sensors(70, 70, 70, 70);
    cyc(6);
    chk("t70_temporal", temporal, 70);
    chk("t70_on_off", on_off, 0);
    chk("t70_led_int", led_int, 0);

    set_sensors(69, 69, 69, 69);
    cyc(6);
    chk("t69_on_off", on_off, 1);
    chk("t69_pot", pot, 90);

    set_sensors(72, 72, 72, 72);
    cyc(6);
    chk("t72_temporal", temporal, 72);
`ifdef UMNI_HYST_EN
    chk("t72_on_off_hold", on_off, 1);
`else
    chk("t72_on_off", on_off, 0);
`endif

    set_sensors(73, 73, 73, 73);
    cyc(6);
    chk("t73_on_off", on_off, 0);

    rst = 1'b1;
    cyc(1);
    chk("mid_rst_led_func", led_func, 0);
    chk("mid_rst_temporal", temporal, 0);
    chk("mid_rst_hum_lig", hum_lig, 0);
    chk("mid_rst_led_lig", led_lig, 0);
    rst = 1'b0;
    cyc(3);
    chk("refill3_led_func", led_func, 0);
    cyc(1);
    chk("refill4_led_func", led_func, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
